// File: rtl/remote_cmd_pkg.sv
// Shared types and constants for the RemoteComm knight-side receiver/transmitter.
package remote_cmd_pkg;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic {
    A_HI = 1'b0,
    A_LO = 1'b1
  } asm_state_t;

  typedef enum logic {
    T_IDLE  = 1'b0,
    T_XMIT  = 1'b1
  } tx_state_t;

  localparam logic [7:0] POS_ACK    = 8'hA5;
  localparam int         FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_core.sv
// UART transmitter: 8N1 frame, LSB first, one baud period per bit, tx_done after the stop bit.
module uart_tx_core
  import remote_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int                BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]     BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0]     BAUD_ONE  = BW'(1);
  localparam logic [3:0]        LAST_BIT  = 4'(FRAME_BITS - 1);

  tx_state_t               state_q, state_d;
  logic [BW-1:0]           baud_q, baud_d;
  logic [3:0]              bit_q, bit_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    done_q, done_d;

  // Next-state: the line is driven straight from shift_q[0], so idle keeps it all ones
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    case (state_q)
      T_IDLE: begin
        if (trmt) begin
          shift_d = {1'b1, tx_data, 1'b0};
          baud_d  = '0;
          bit_d   = 4'd0;
          state_d = T_XMIT;
        end else begin
          shift_d = '1;
        end
      end
      T_XMIT: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == LAST_BIT) begin
            shift_d = '1;
            done_d  = 1'b1;
            state_d = T_IDLE;
          end else begin
            shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        shift_d = '1;
        state_d = T_IDLE;
      end
    endcase
  end

  // State registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= T_IDLE;
      baud_q  <= '0;
      bit_q   <= 4'd0;
      shift_q <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  assign TX      = shift_q[0];
  assign tx_done = done_q;

endmodule

// File: rtl/remote_cmd_rx.sv
// Knight-side RemoteComm endpoint: deserialises two RX bytes into a 16-bit cmd, transmits resp on TX.
module remote_cmd_rx
  import remote_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604,
  parameter int TMO_BITS = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  localparam int            BW        = $clog2(BAUD_DIV);
  localparam int            TW        = $clog2(TMO_BITS * BAUD_DIV + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'((BAUD_DIV >> 1) - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_BITS * BAUD_DIV - 1);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);

  logic          rx_meta_q, rx_s_q, rx_prev_q;
  rx_state_t     rx_state_q, rx_state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          byte_vld_q, byte_vld_d, frm_err_q, frm_err_d;
  logic          start_s;
  asm_state_t    asm_q, asm_d;
  logic [7:0]    hi_q, hi_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          rdy_q, rdy_d, rdy_set_s, rdy_clr_s;

  // RX deserialiser: start on a falling edge, re-check at half-bit, then sample mid-bit
  always_comb begin
    rx_state_d = rx_state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    data_d     = data_q;
    byte_vld_d = 1'b0;
    frm_err_d  = 1'b0;
    start_s    = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          start_s    = 1'b1;
          baud_d     = '0;
          rx_state_d = R_START;
        end else begin
          baud_d = '0;
        end
      end
      R_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d     = '0;
          bit_d      = 3'd0;
          rx_state_d = rx_s_q ? R_IDLE : R_DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      R_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          data_d = {rx_s_q, data_q[7:1]};
          if (bit_q == 3'd7) begin
            rx_state_d = R_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      R_STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d     = '0;
          byte_vld_d = rx_s_q;
          frm_err_d  = ~rx_s_q;
          rx_state_d = R_IDLE;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        baud_d     = '0;
        rx_state_d = R_IDLE;
      end
    endcase
  end

  // Byte pairing: a stale high byte is dropped on framing error or inter-byte timeout
  always_comb begin
    asm_d     = asm_q;
    hi_d      = hi_q;
    tmo_d     = tmo_q;
    cmd_d     = cmd_q;
    rdy_set_s = 1'b0;
    rdy_clr_s = clr_cmd_rdy || (start_s && (asm_q == A_HI));
    case (asm_q)
      A_HI: begin
        if (byte_vld_q) begin
          hi_d  = data_q;
          tmo_d = '0;
          asm_d = A_LO;
        end else begin
          tmo_d = '0;
        end
      end
      A_LO: begin
        if (byte_vld_q) begin
          cmd_d     = {hi_q, data_q};
          rdy_set_s = 1'b1;
          tmo_d     = '0;
          asm_d     = A_HI;
        end else if (frm_err_q) begin
          tmo_d = '0;
          asm_d = A_HI;
        end else if (rx_state_q == R_IDLE) begin
          if (tmo_q == TMO_LAST) begin
            tmo_d = '0;
            asm_d = A_HI;
          end else begin
            tmo_d = tmo_q + TMO_ONE;
          end
        end else begin
          tmo_d = tmo_q;
        end
      end
      default: begin
        tmo_d = '0;
        asm_d = A_HI;
      end
    endcase
    if (rdy_set_s) begin
      rdy_d = 1'b1;
    end else if (rdy_clr_s) begin
      rdy_d = 1'b0;
    end else begin
      rdy_d = rdy_q;
    end
  end

  // All receive-side registers; synchroniser flops preset high so reset looks like idle line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= R_IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      data_q     <= 8'h00;
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
      asm_q      <= A_HI;
      hi_q       <= 8'h00;
      tmo_q      <= '0;
      cmd_q      <= 16'h0000;
      rdy_q      <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      rx_state_q <= rx_state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      byte_vld_q <= byte_vld_d;
      frm_err_q  <= frm_err_d;
      asm_q      <= asm_d;
      hi_q       <= hi_d;
      tmo_q      <= tmo_d;
      cmd_q      <= cmd_d;
      rdy_q      <= rdy_d;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = rdy_q;

  uart_tx_core #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (resp),
    .TX      (TX),
    .tx_done (tx_done)
  );

endmodule

// File: tb/tb_remote_cmd_rx.sv
// Directed bench for remote_cmd_rx: bit-banged RX frames and a checked TX frame at BAUD_DIV=16.
module tb_remote_cmd_rx;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'hA5;
  logic        trmt = 1'b0;
  logic        tx_done;

  int checks = 0;
  int errors = 0;

  remote_cmd_rx #(
    .BAUD_DIV(BD),
    .TMO_BITS(40)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .trmt        (trmt),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one frame from a negedge; samples cmd_rdy just before and just after the set point.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic clr_at_set,
                           output logic r155, output logic r156);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 9; i++) begin
      RX = fr[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop_bit;
    repeat (11) @(negedge clk);
    r155 = cmd_rdy;
    clr_cmd_rdy = clr_at_set;
    @(negedge clk);
    r156 = cmd_rdy;
    clr_cmd_rdy = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic tx_frame(input logic mid_trmt);
    logic [9:0] fr;
    int w;
    fr = {1'b1, 8'hA5, 1'b0};
    resp = 8'hA5;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    w = 8;
    for (int k = 0; k < 10; k++) begin
      repeat (w) @(negedge clk);
      check_val($sformatf("tx_bit%0d", k), TX, fr[k]);
      w = 16;
      if (mid_trmt && k == 3) begin
        resp = 8'h00;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        resp = 8'hA5;
        w = 15;
      end
    end
    repeat (7) @(negedge clk);
    check_val("tx_done_early", tx_done, 1'b0);
    @(negedge clk);
    check_val("tx_done_pulse", tx_done, 1'b1);
    @(negedge clk);
    check_val("tx_done_end", tx_done, 1'b0);
    check_val("tx_idle_high", TX, 1'b1);
  endtask

  initial begin
    logic r155, r156, r155b, r156b, seen_done;

    repeat (3) @(negedge clk);
    check_val("rst_tx", TX, 1'b1);
    check_val("rst_cmd", cmd, 16'h0000);
    check_val("rst_rdy", cmd_rdy, 1'b0);
    check_val("rst_tx_done", tx_done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-byte command
    send_byte(8'h43, 1'b1, 1'b0, r155, r156);
    check_val("hi_only_rdy", r156, 1'b0);
    send_byte(8'hF1, 1'b1, 1'b0, r155, r156);
    check_val("rdy_before_set", r155, 1'b0);
    check_val("rdy_after_set", r156, 1'b1);
    check_val("cmd_43F1", cmd, 16'h43F1);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    check_val("clr_rdy", cmd_rdy, 1'b0);
    check_val("clr_cmd_held", cmd, 16'h43F1);

    // Framing error on the low byte drops the pair
    send_byte(8'h43, 1'b1, 1'b0, r155, r156);
    send_byte(8'hF1, 1'b0, 1'b0, r155, r156);
    RX = 1'b1;
    repeat (2 * BD) @(negedge clk);
    check_val("frm_rdy", cmd_rdy, 1'b0);
    check_val("frm_cmd_held", cmd, 16'h43F1);
    send_byte(8'h12, 1'b1, 1'b0, r155, r156);
    send_byte(8'h34, 1'b1, 1'b0, r155, r156);
    check_val("rdy_1234", r156, 1'b1);
    check_val("cmd_1234", cmd, 16'h1234);

    // Inter-byte timeout discards the high byte
    send_byte(8'h43, 1'b1, 1'b0, r155, r156);
    RX = 1'b1;
    repeat (41 * BD) @(negedge clk);
    check_val("tmo_cmd_held", cmd, 16'h1234);
    check_val("tmo_rdy_cleared", cmd_rdy, 1'b0);
    send_byte(8'h25, 1'b1, 1'b0, r155, r156);
    check_val("tmo_new_hi_rdy", r156, 1'b0);
    send_byte(8'hBF, 1'b1, 1'b0, r155, r156);
    check_val("cmd_25BF", cmd, 16'h25BF);
    check_val("rdy_25BF", r156, 1'b1);

    // Short low glitch: no byte, but the aborted start still clears cmd_rdy
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (40) @(negedge clk);
    check_val("glitch_cmd", cmd, 16'h25BF);
    check_val("glitch_rdy", cmd_rdy, 1'b0);

    // Full duplex: TX frame with ignored mid-frame trmt alongside a command with clear-on-set
    fork
      tx_frame(1'b1);
      begin
        send_byte(8'h56, 1'b1, 1'b0, r155b, r156b);
        send_byte(8'h78, 1'b1, 1'b1, r155b, r156b);
      end
    join
    check_val("set_wins_rdy", r156b, 1'b1);
    check_val("cmd_5678", cmd, 16'h5678);
    check_val("rdy_held", cmd_rdy, 1'b1);

    // Reset in the middle of a TX frame
    resp = 8'h00;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    repeat (40) @(negedge clk);
    check_val("tx_mid_low", TX, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("rst_mid_tx", TX, 1'b1);
    check_val("rst_mid_cmd", cmd, 16'h0000);
    check_val("rst_mid_rdy", cmd_rdy, 1'b0);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_done) seen_done = 1'b1;
    end
    check_val("rst_no_tx_done", seen_done, 1'b0);
    check_val("rst_tx_stays_high", TX, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
